// File: rtl/comp_edge_pkg.sv
// rtl/comp_edge_pkg.sv - shared types and helpers for the edge arbiter
// Purpose: FSM state type, width helpers, priority-encode and multi-bit tests.
// Ports: none (package).
package comp_edge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Index width never collapses to zero, even for a single channel.
  function automatic int calc_iw(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int calc_tw(input int window);
    return $clog2(window);
  endfunction

  // Lowest set bit wins (channel 0 has highest priority).
  function automatic int lowest_set_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_set(input logic [31:0] v);
    return (v & (v - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/comp_edge_chan.sv
// rtl/comp_edge_chan.sv - per-channel rise detect, arrival flag and timestamp
// Purpose: one edge line; flags its first 0->1 transition inside the window.
// Ports: clk, rst_b (async, active low), i_clear (window re-arm),
//        i_sample (window open and not restarting), i_timer, i_edge,
//        o_new (first arrival this cycle), o_arrived, o_time.
// Optional: COMP_EDGE_TIMESTAMP_EN keeps the per-channel timestamp register.
module comp_edge_chan
  import comp_edge_pkg::*;
#(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          i_clear,
  input  logic          i_sample,
  input  logic [TW-1:0] i_timer,
  input  logic          i_edge,
  output logic          o_new,
  output logic          o_arrived,
  output logic [TW-1:0] o_time
);

  logic r_edge_q;
  logic r_arrived;
  logic w_rise;

  // History runs in every state, so a line already high at arming never counts.
  assign w_rise    = i_edge & ~r_edge_q;
  assign o_new     = i_sample & w_rise & ~r_arrived;
  assign o_arrived = r_arrived;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_edge_q  <= 1'b0;
      r_arrived <= 1'b0;
    end else begin
      r_edge_q <= i_edge;
      if (i_clear)    r_arrived <= 1'b0;
      else if (o_new) r_arrived <= 1'b1;
    end
  end

`ifdef COMP_EDGE_TIMESTAMP_EN
  logic [TW-1:0] r_time;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)       r_time <= '0;
    else if (i_clear) r_time <= '0;
    else if (o_new)   r_time <= i_timer;
  end

  assign o_time = r_time;
`else
  logic w_unused_timer;
  assign w_unused_timer = ^i_timer;
  assign o_time         = '0;
`endif

endmodule

// File: rtl/comp_edge_arbiter.sv
// rtl/comp_edge_arbiter.sv - windowed first-edge arbiter with tie detection
// Purpose: arms a WINDOW-cycle window on start, reports earliest channel,
//          its arrival time, tie and the arrival vector.
// Ports: clk, rst_b (async, active low), start, edge_in[N_CH];
//        busy, done, any_arrived, winner_idx[IW], winner_time[TW], tie,
//        arrived[N_CH], arr_time[N_CH*TW] (channel i at [i*TW +: TW]).
// Optional: COMP_EDGE_TIMESTAMP_EN populates arr_time; otherwise it is 0.
// N_CH is limited to 32 by the package priority helpers.
module comp_edge_arbiter
  import comp_edge_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int WINDOW = 16,
  localparam int IW     = calc_iw(N_CH),
  localparam int TW     = calc_tw(WINDOW)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic [N_CH-1:0]   edge_in,
  output logic              busy,
  output logic              done,
  output logic              any_arrived,
  output logic [IW-1:0]     winner_idx,
  output logic [TW-1:0]     winner_time,
  output logic              tie,
  output logic [N_CH-1:0]   arrived,
  output logic [N_CH*TW-1:0] arr_time
);

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic            r_any;
  logic            r_tie;
  logic [IW-1:0]   r_widx;
  logic [TW-1:0]   r_wtime;

  logic [N_CH-1:0] w_new;
  logic [N_CH-1:0] w_arrived;
  logic [31:0]     w_new_ext;
  logic            w_sample;
  logic            w_all;
  logic            w_last;

  // A start while armed discards that cycle's arrivals.
  assign w_sample  = (r_state == ARMED) & ~start;
  assign w_new_ext = 32'(w_new);
  assign w_all     = (w_arrived | w_new) == {N_CH{1'b1}};
  assign w_last    = r_timer == TW'(WINDOW - 1);

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    logic [TW-1:0] w_time;

    comp_edge_chan #(.TW(TW)) u_chan (
      .clk       (clk),
      .rst_b     (rst_b),
      .i_clear   (start),
      .i_sample  (w_sample),
      .i_timer   (r_timer),
      .i_edge    (edge_in[g]),
      .o_new     (w_new[g]),
      .o_arrived (w_arrived[g]),
      .o_time    (w_time)
    );

    assign arr_time[g*TW +: TW] = w_time;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_any   <= 1'b0;
      r_tie   <= 1'b0;
      r_widx  <= '0;
      r_wtime <= '0;
    end else if (start) begin
      // Honoured in every state: arm from IDLE/DONE, restart when ARMED.
      r_state <= ARMED;
      r_timer <= '0;
      r_any   <= 1'b0;
      r_tie   <= 1'b0;
      r_widx  <= '0;
      r_wtime <= '0;
    end else begin
      case (r_state)
        ARMED: begin
          // Only the first cycle with arrivals decides winner and tie.
          if ((w_new != '0) && !r_any) begin
            r_any   <= 1'b1;
            r_widx  <= IW'(lowest_set_idx(w_new_ext));
            r_wtime <= r_timer;
            r_tie   <= multi_set(w_new_ext);
          end
          if (w_all || w_last) r_state <= DONE;
          else                 r_timer <= r_timer + TW'(1);
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state == ARMED);
  assign done        = (r_state == DONE);
  assign any_arrived = r_any;
  assign winner_idx  = r_widx;
  assign winner_time = r_wtime;
  assign tie         = r_tie;
  assign arrived     = w_arrived;

endmodule

// File: tb/tb_comp_edge_arbiter.sv
// tb/tb_comp_edge_arbiter.sv - self-checking bench for comp_edge_arbiter
module tb_comp_edge_arbiter;

  localparam int N_CH   = 4;
  localparam int WINDOW = 16;
  localparam int TW     = 4;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  edge_in = 4'd0;
  logic        busy, done, any_arrived, tie;
  logic [1:0]  winner_idx;
  logic [3:0]  winner_time;
  logic [3:0]  arrived;
  logic [15:0] arr_time;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]  pre_lv;
  logic [3:0]  lv [WINDOW];

  logic        exp_any, exp_tie;
  logic [1:0]  exp_idx;
  logic [3:0]  exp_wt, exp_arr;
  logic [15:0] exp_at;
  int          exp_end;

  comp_edge_arbiter #(.N_CH(N_CH), .WINDOW(WINDOW)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start       (start),
    .edge_in     (edge_in),
    .busy        (busy),
    .done        (done),
    .any_arrived (any_arrived),
    .winner_idx  (winner_idx),
    .winner_time (winner_time),
    .tie         (tie),
    .arrived     (arrived),
    .arr_time    (arr_time)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: walk the window cycle by cycle on the level sequence.
  function automatic void model();
    logic [3:0] prev, nw, arr;
    prev = pre_lv; arr = 4'd0;
    exp_any = 1'b0; exp_tie = 1'b0; exp_idx = 2'd0; exp_wt = 4'd0;
    exp_at = 16'd0; exp_end = WINDOW - 1;
    for (int k = 0; k < WINDOW; k++) begin
      nw = lv[k] & ~prev & ~arr;
      prev = lv[k];
      if (nw != 4'd0 && !exp_any) begin
        exp_any = 1'b1;
        exp_wt  = 4'(k);
        exp_tie = ($countones(nw) > 1);
        for (int i = N_CH - 1; i >= 0; i--) if (nw[i]) exp_idx = 2'(i);
      end
      for (int i = 0; i < N_CH; i++) if (nw[i]) exp_at[i*TW +: TW] = 4'(k);
      arr = arr | nw;
      if (arr == 4'hF) begin
        exp_end = k;
        break;
      end
    end
    exp_arr = arr;
  endfunction

  function automatic logic [15:0] exp_arr_time();
`ifdef COMP_EDGE_TIMESTAMP_EN
    return exp_at;
`else
    return 16'd0;
`endif
  endfunction

  task automatic check_results(input string p);
    check({p, "_any"},  any_arrived, exp_any);
    check({p, "_idx"},  winner_idx,  exp_idx);
    check({p, "_wt"},   winner_time, exp_wt);
    check({p, "_tie"},  tie,         exp_tie);
    check({p, "_arr"},  arrived,     exp_arr);
    check({p, "_at"},   arr_time,    exp_arr_time());
  endtask

  task automatic check_zero(input string p);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_any"},  any_arrived, 0);
    check({p, "_idx"},  winner_idx, 0);
    check({p, "_wt"},   winner_time, 0);
    check({p, "_tie"},  tie, 0);
    check({p, "_arr"},  arrived, 0);
    check({p, "_at"},   arr_time, 0);
  endtask

  // Called positioned just after the edge that opens the start cycle;
  // returns positioned in the DONE cycle.
  task automatic run_window();
    model();
    start = 1'b1;
    edge_in = pre_lv;
    for (int k = 0; k <= exp_end; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      edge_in = lv[k];
      check("busy_armed", busy, 1);
      check("no_early_done", done, 0);
    end
    @(posedge clk); #1;
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
    check_results("done");
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    check_results("hold");
  endtask

  // Start and run n cycles without checks, leaving the next cycle current.
  task automatic partial_run(input int n);
    start = 1'b1;
    edge_in = pre_lv;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      edge_in = lv[k];
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_levels();
    logic [3:0] cur;
    cur = pre_lv;
    for (int k = 0; k < WINDOW; k++) begin
      for (int i = 0; i < N_CH; i++) if ($urandom_range(0, 3) == 0) cur[i] = ~cur[i];
      lv[k] = cur;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_b = 1'b1;
    @(posedge clk); #1;
    check_zero("post_reset");

    // ch2 at k=3, ch0 at k=5
    pre_lv = 4'd0;
    for (int k = 0; k < WINDOW; k++) lv[k] = ((k >= 3) ? 4'b0100 : 4'b0000) | ((k >= 5) ? 4'b0001 : 4'b0000);
    run_window();
    check("tp1_idx", winner_idx, 2);
    check("tp1_wt", winner_time, 3);
    check("tp1_arr", arrived, 4'b0101);
    idle_check();

    // ch1+ch3 at k=2, ch0+ch2 at k=4; next start issued in the DONE cycle
    @(posedge clk); #1;
    pre_lv = 4'd0;
    for (int k = 0; k < WINDOW; k++) lv[k] = ((k >= 2) ? 4'b1010 : 4'b0000) | ((k >= 4) ? 4'b0101 : 4'b0000);
    run_window();
    check("tp2_idx", winner_idx, 1);
    check("tp2_tie", tie, 1);
`ifdef COMP_EDGE_TIMESTAMP_EN
    check("tp2_at", arr_time, 16'h2424);
`else
    check("tp2_at", arr_time, 16'h0000);
`endif

    // ch0 held high from before the window
    pre_lv = 4'b0001;
    for (int k = 0; k < WINDOW; k++) lv[k] = 4'b0001;
    run_window();
    check("tp3_any", any_arrived, 0);
    check("tp3_arr0", arrived[0], 0);
    idle_check();

    // ch3 at k=6, restart at k=8, ch1 two cycles after the restart
    @(posedge clk); #1;
    pre_lv = 4'd0;
    for (int k = 0; k < WINDOW; k++) lv[k] = (k >= 6) ? 4'b1000 : 4'b0000;
    partial_run(8);
    pre_lv = 4'b1000;
    for (int k = 0; k < WINDOW; k++) lv[k] = 4'b1000 | ((k >= 1) ? 4'b0010 : 4'b0000);
    run_window();
    check("tp4_idx", winner_idx, 1);
    check("tp4_wt", winner_time, 1);
    check("tp4_arr", arrived, 4'b0010);
    idle_check();

    // reset in the middle of a window
    @(posedge clk); #1;
    pre_lv = 4'd0;
    for (int k = 0; k < WINDOW; k++) lv[k] = (k >= 1) ? 4'b0100 : 4'b0000;
    partial_run(4);
    rst_b = 1'b0;
    #1;
    check_zero("mid_reset");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_zero("in_reset");
    end
    rst_b = 1'b1;
    @(posedge clk); #1;
    check_zero("after_release");
    pre_lv = 4'd0;
    for (int k = 0; k < WINDOW; k++)
      lv[k] = 4'b0110 | ((k >= 9) ? 4'b0001 : 4'b0000) | ((k >= 12) ? 4'b1000 : 4'b0000);
    run_window();
    check("rst_new_idx", winner_idx, 1);
    check("rst_new_tie", tie, 1);
    idle_check();

    // randomized windows with occasional restarts and back-to-back starts
    for (int w = 0; w < 40; w++) begin
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 3) == 0) begin
        pre_lv = 4'($urandom_range(0, 15));
        rand_levels();
        partial_run(int'($urandom_range(1, 10)));
      end
      pre_lv = 4'($urandom_range(0, 15));
      rand_levels();
      run_window();
      if ($urandom_range(0, 1) == 0) idle_check();
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
